ay8_bus_memory: RTL and testbench
=================================

Name: ay8_bus_memory

Overview:
- Instruction/data memory slave that sits directly downstream of the AY8 fetch sequencer on the unified 8-bit bus.
- Accepts a one-cycle command with the address on the bus, optionally inserts wait states, then completes the transfer in a one-cycle data phase:
  - on a read, it drives the stored byte back onto the bus;
  - on a write, it captures the bus byte.
- Also provides a side-band program-load port so the bench or boot logic can fill memory before the CPU runs.

Parameters:
- DEPTH, 256: number of 8-bit words; addresses ≥ DEPTH alias modulo DEPTH (DEPTH is a power of two, at most 256).
- WAIT_CYCLES, 0: wait states inserted between the address phase and the data phase (0..15).

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
- cmd_valid  in  1  command strobe; bus_in holds the address this cycle.
- cmd_rw  in  1  0 = READ, 1 = WRITE; sampled with cmd_valid.
- bus_in  in  8  value currently on the unified bus (address in the address phase, write data in the data phase).
- bus_out  out  8  read data to drive onto the bus.
- bus_oe  out  1  tri-state enable for bus_out; the top level drives the bus only when this is 1.
- ack  out  1  high for exactly one cycle, during the data phase.
- busy  out  1  high whenever the state is not IDLE.
- cmd_drop  out  1  sticky flag, set when cmd_valid arrives while busy; cleared only by reset.
- ld_en  in  1  program-load write enable; honoured only in IDLE with cmd_valid=0.
- ld_addr  in  8  program-load address.
- ld_data  in  8  program-load data.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state←IDLE, bus_out←0, bus_oe←0, ack←0, busy←0, cmd_drop←0, wait counter←0.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons the transfer. A pending write is not performed. bus_oe is low in the cycle after the reset edge.
- FSM states:
  - IDLE: in cycle T with cmd_valid=1, latch addr←bus_in mod DEPTH and rw←cmd_rw. Next state is WAIT if WAIT_CYCLES>0 (counter←WAIT_CYCLES-1), otherwise DATA. ld_en is ignored in a cycle where cmd_valid=1.
  - WAIT: the counter decrements each cycle; go to DATA when the counter is 0 at the edge. Total time in WAIT is exactly WAIT_CYCLES cycles.
  - DATA: exactly one cycle, after which the state returns to IDLE.
- Read latency: the data phase is cycle T+1+WAIT_CYCLES.
  - bus_out is registered, loaded from mem[addr] on the edge entering DATA.
  - bus_oe=1 and ack=1 during the DATA cycle only.
  - bus_oe is 0 in every other cycle, including all write data phases, so there is no contention with the master.
- Write:
  - During the DATA cycle, ack=1 and bus_oe=0.
  - mem[addr]←bus_in on the edge ending the DATA cycle; the value is visible to a read issued in the following cycle.
- Back-to-back: a new cmd_valid is accepted in the first IDLE cycle after DATA. Minimum spacing is 2+WAIT_CYCLES cycles.
- cmd_valid while busy: the command is ignored (no state change) and cmd_drop←1.
- Program load: mem[ld_addr mod DEPTH]←ld_data when ld_en=1, state=IDLE and cmd_valid=0. Otherwise it is silently ignored; cmd_drop is not set.
- Simultaneous RST and cmd_valid: reset wins and the command is not latched.
- Width rules: address and data are 8 bits; no arithmetic beyond the 4-bit wait counter.

Decomposition:
- Shared package ay8_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, DATA} for the state;
  - constants READ=1'b0 and WRITE=1'b1, shared with the fetch sequencer's command encoding;
  - the DATA_W=8 constant.
- One natural sub-module: ay8_sram_1rw, a DEPTH×8 single-port synchronous RAM with one write port and one registered read. Its write mux is fed by either the DATA phase or the load port.

Test Plan:
1. Load: ld_en writes 0x3C at addr 0x05 and 0xA7 at 0x06. Then, with WAIT_CYCLES=0, cmd_valid READ with bus_in=0x05 in cycle T → cycle T+1 has bus_out=0x3C, bus_oe=1, ack=1; cycle T+2 has bus_oe=0 and busy=0.
2. WAIT_CYCLES=3, READ of 0x06 issued in cycle T → busy for T+1..T+4, ack and bus_oe only in T+4, bus_out=0xA7, exactly one ack pulse.
3. WRITE to 0x10: address 0x10 in cycle T, bus_in=0x5A in T+1 → ack in T+1 with bus_oe=0; READ of 0x10 issued in T+2 returns 0x5A in T+3.
4. WAIT_CYCLES=2, second cmd_valid while busy → command ignored, the original transfer completes normally, cmd_drop=1 and it stays 1 until RST.
5. RST asserted in the WAIT cycle of a WRITE to 0x20 (old value 0x11) → next cycle busy=0, bus_oe=0, ack=0, cmd_drop=0; a later READ of 0x20 returns 0x11.
6. ld_en=1 with ld_data=0xFF at 0x05 while busy or while cmd_valid=1 → ignored; a later READ of 0x05 still returns 0x3C.

Source files
------------

// File: rtl/ay8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ay8_pkg
//  Brief    : Shared AY8 bus types and command encoding.
//  Revision : 1.0
// ============================================================================
package ay8_pkg;

    localparam int DATA_W = 8;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } bus_state_t;

endpackage : ay8_pkg
`default_nettype wire

// File: rtl/ay8_sram_1rw.sv
`default_nettype none
// ============================================================================
//  Module   : ay8_sram_1rw
//  Brief    : DEPTH x DATA_W synchronous RAM, one write port, registered read.
//  Revision : 1.0
// ============================================================================
module ay8_sram_1rw
    import ay8_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array is deliberately left out of reset so contents survive RST.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : ay8_sram_1rw
`default_nettype wire

// File: rtl/ay8_bus_memory.sv
`default_nettype none
// ============================================================================
//  Module   : ay8_bus_memory
//  Brief    : AY8 unified-bus memory slave with wait states and program load.
//  Revision : 1.0
// ============================================================================
module ay8_bus_memory
    import ay8_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    input  logic              cmd_rw,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              ack,
    output logic              busy,
    output logic              cmd_drop,
    input  logic              ld_en,
    input  logic [7:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    logic [AW-1:0]     r_addr;
    logic              r_rw;
    logic [3:0]        r_cnt;
    logic              r_cmd_drop;

    logic              w_accept;
    logic              w_enter_data;
    logic              w_data_wr;
    logic              w_ld_wr;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [AW-1:0]     w_raddr;

    assign w_accept = (r_state == IDLE) && cmd_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : DATA;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DATA;
                end
            end
            DATA:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr     <= '0;
            r_rw       <= READ;
            r_cnt      <= 4'd0;
            r_cmd_drop <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= bus_in[AW-1:0];
                r_rw   <= cmd_rw;
                r_cnt  <= c_wait_init;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (cmd_valid && (r_state != IDLE)) begin
                r_cmd_drop <= 1'b1;
            end
        end
    end

    // With zero wait states the read launches straight from the address phase.
    assign w_enter_data = (w_state_nxt == DATA) && (r_state != DATA);
    assign w_raddr      = (r_state == IDLE) ? bus_in[AW-1:0] : r_addr;

    // DATA-phase writes and loads are mutually exclusive (DATA vs IDLE).
    assign w_data_wr = (r_state == DATA) && (r_rw == WRITE) && !RST;
    assign w_ld_wr   = ld_en && (r_state == IDLE) && !cmd_valid;
    assign w_we      = w_data_wr || w_ld_wr;
    assign w_waddr   = w_data_wr ? r_addr : ld_addr[AW-1:0];
    assign w_wdata   = w_data_wr ? bus_in : ld_data;

    ay8_sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (CLK),
        .rst     (RST),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_enter_data),
        .i_raddr (w_raddr),
        .o_rdata (bus_out)
    );

    assign bus_oe   = (r_state == DATA) && (r_rw == READ);
    assign ack      = (r_state == DATA);
    assign busy     = (r_state != IDLE);
    assign cmd_drop = r_cmd_drop;

endmodule : ay8_bus_memory
`default_nettype wire

// File: tb/tb_ay8_bus_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ay8_bus_memory
//  Brief    : Directed bench for ay8_bus_memory at WAIT_CYCLES of 0, 2 and 3.
//  Revision : 1.0
// ============================================================================
module tb_ay8_bus_memory;

    logic       CLK;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_rw;
    logic [7:0] bus_in;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    // Index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=2, 2: WAIT_CYCLES=3
    logic [7:0] bo [3];
    logic       oe [3];
    logic       ak [3];
    logic       by [3];
    logic       dr [3];

    int n_err = 0;
    int n_chk = 0;
    int acks;

    ay8_bus_memory #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .bus_in(bus_in),
        .bus_out(bo[0]), .bus_oe(oe[0]), .ack(ak[0]), .busy(by[0]), .cmd_drop(dr[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    ay8_bus_memory #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .bus_in(bus_in),
        .bus_out(bo[1]), .bus_oe(oe[1]), .ack(ak[1]), .busy(by[1]), .cmd_drop(dr[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    ay8_bus_memory #(.DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .bus_in(bus_in),
        .bus_out(bo[2]), .bus_oe(oe[2]), .ack(ak[2]), .busy(by[2]), .cmd_drop(dr[2]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic rw, input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        bus_in    = a;
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; bus_in = 8'h00;
        ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 8'(by[i]), 8'd0);
            chk("rst_oe",   8'(oe[i]), 8'd0);
            chk("rst_ack",  8'(ak[i]), 8'd0);
            chk("rst_drop", 8'(dr[i]), 8'd0);
            chk("rst_bus_out", bo[i], 8'h00);
        end
        RST = 1'b0;

        // Program load
        ld_en = 1'b1; ld_addr = 8'h05; ld_data = 8'h3C; tick();
        ld_addr = 8'h06; ld_data = 8'hA7; tick();
        ld_addr = 8'h20; ld_data = 8'h11; tick();
        ld_en = 1'b0;

        // Zero-wait read
        cmd(1'b0, 8'h05); tick(); cmd_valid = 1'b0;
        chk("t1_data", bo[0], 8'h3C);
        chk("t1_oe",   8'(oe[0]), 8'd1);
        chk("t1_ack",  8'(ak[0]), 8'd1);
        tick();
        chk("t1_oe_after",   8'(oe[0]), 8'd0);
        chk("t1_busy_after", 8'(by[0]), 8'd0);
        idle(5);

        // Three wait states
        cmd(1'b0, 8'h06); tick(); cmd_valid = 1'b0;
        acks = 0;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_busy", 8'(by[2]), 8'd1);
            chk("t2_ack",  8'(ak[2]), (k == 4) ? 8'd1 : 8'd0);
            chk("t2_oe",   8'(oe[2]), (k == 4) ? 8'd1 : 8'd0);
            acks += int'(ak[2]);
            if (k == 4) chk("t2_data", bo[2], 8'hA7);
            tick();
        end
        chk("t2_busy_after", 8'(by[2]), 8'd0);
        chk("t2_ack_after",  8'(ak[2]), 8'd0);
        chk("t2_ack_count",  8'(acks), 8'd1);
        idle(5);

        // Write followed by read-back
        cmd(1'b1, 8'h10); tick(); cmd_valid = 1'b0; bus_in = 8'h5A;
        chk("t3_wr_ack", 8'(ak[0]), 8'd1);
        chk("t3_wr_oe",  8'(oe[0]), 8'd0);
        tick();
        cmd(1'b0, 8'h10); tick(); cmd_valid = 1'b0;
        chk("t3_rd_data", bo[0], 8'h5A);
        chk("t3_rd_oe",   8'(oe[0]), 8'd1);
        chk("t3_rd_ack",  8'(ak[0]), 8'd1);
        idle(6);

        RST = 1'b1; tick(); RST = 1'b0;
        for (int i = 0; i < 3; i++) chk("pre_t4_drop", 8'(dr[i]), 8'd0);

        // Command while busy, WAIT_CYCLES=2
        cmd(1'b0, 8'h05); tick(); cmd(1'b0, 8'h06);
        chk("t4_drop_pre", 8'(dr[1]), 8'd0);
        tick(); cmd_valid = 1'b0;
        chk("t4_drop_set", 8'(dr[1]), 8'd1);
        chk("t4_busy",     8'(by[1]), 8'd1);
        chk("t4_ack_wait", 8'(ak[1]), 8'd0);
        tick();
        chk("t4_ack",  8'(ak[1]), 8'd1);
        chk("t4_oe",   8'(oe[1]), 8'd1);
        chk("t4_data", bo[1], 8'h3C);
        tick();
        chk("t4_busy_after", 8'(by[1]), 8'd0);
        chk("t4_drop_hold",  8'(dr[1]), 8'd1);
        idle(8);
        chk("t4_drop_sticky", 8'(dr[1]), 8'd1);

        // Reset during WAIT of a write (also lands on the zero-wait DATA cycle)
        cmd(1'b1, 8'h20); tick(); cmd_valid = 1'b0; bus_in = 8'hEE; RST = 1'b1;
        tick(); RST = 1'b0;
        chk("t5_busy", 8'(by[1]), 8'd0);
        chk("t5_oe",   8'(oe[1]), 8'd0);
        chk("t5_ack",  8'(ak[1]), 8'd0);
        chk("t5_drop", 8'(dr[1]), 8'd0);
        cmd(1'b0, 8'h20); tick(); cmd_valid = 1'b0;
        chk("t5_w0_data", bo[0], 8'h11);
        tick(); tick();
        chk("t5_data", bo[1], 8'h11);
        chk("t5_ack_rd", 8'(ak[1]), 8'd1);
        chk("t5_oe_rd",  8'(oe[1]), 8'd1);
        idle(6);

        // Load attempts during cmd_valid and busy are ignored
        cmd(1'b0, 8'h06); ld_en = 1'b1; ld_addr = 8'h05; ld_data = 8'hFF;
        tick(); cmd_valid = 1'b0;
        chk("t6_rd06", bo[0], 8'hA7);
        tick(); ld_en = 1'b0;
        idle(6);
        cmd(1'b0, 8'h05); tick(); cmd_valid = 1'b0;
        chk("t6_data", bo[0], 8'h3C);
        chk("t6_drop", 8'(dr[0]), 8'd0);
        idle(6);
        cmd(1'b0, 8'h05); tick(); cmd_valid = 1'b0;
        idle(3);
        chk("t6_w3_data", bo[2], 8'h3C);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_ay8_bus_memory
`default_nettype wire
